id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register that feeds the EX-stage ALU: src1_o, src2_o and alu_ctrl_o drive the ALU's src1_i, src2_i and ctrl_i directly.
- Selects operands: register, immediate, or shamt.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, both at capture and while held.
- Uses a valid/ready handshake with synchronous flush.
- Provides a saturating stall counter for performance debug.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.
- CW, 16, stall counter width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- id_valid_i  in  1  ID holds a valid decoded instruction.
- id_ready_o  out  1  stage can accept this cycle.
- id_rs_data_i  in  DW  register-file rs read data.
- id_rt_data_i  in  DW  register-file rt read data.
- id_rs_addr_i  in  AW  rs index.
- id_rt_addr_i  in  AW  rt index.
- id_rd_addr_i  in  AW  destination index.
- id_imm_i  in  DW  already-extended immediate.
- id_shamt_i  in  5  shift amount field.
- id_alu_ctrl_i  in  4  ALU control code (0000 AND … 1001 SRAV).
- id_alu_src_i  in  1  1: src2 = immediate.
- id_shift_src_i  in  1  1: src1 = zero-extended shamt (SRA).
- id_reg_write_i  in  1  instruction writes rd.
- exm_we_i  in  1  EX/MEM will write back.
- exm_addr_i  in  AW  EX/MEM dest index.
- exm_data_i  in  DW  EX/MEM result.
- wb_we_i  in  1  MEM/WB writing back.
- wb_addr_i  in  AW  MEM/WB dest index.
- wb_data_i  in  DW  MEM/WB write data.
- flush_i  in  1  kill held and incoming instruction.
- ex_ready_i  in  1  EX accepts the held instruction.
- ex_valid_o  out  1  outputs hold a valid instruction.
- src1_o  out  DW  ALU operand 1.
- src2_o  out  DW  ALU operand 2.
- alu_ctrl_o  out  4  ALU control.
- rd_addr_o  out  AW  destination index.
- reg_write_o  out  1  write enable, qualified by ex_valid_o.
- stall_cnt_o  out  CW  count of held cycles.

Behaviour:
- Reset (async, rst_i=1): ex_valid_o=0; src1_o, src2_o, alu_ctrl_o, rd_addr_o, reg_write_o, stall_cnt_o = 0; internal rs/rt addresses and selector flags = 0. Outputs are registered.
- id_ready_o = !ex_valid_o | ex_ready_i | flush_i. This is combinational and the only comb path. No dependence on id_valid_i.
- Accept: id_valid_i & id_ready_o & !flush_i. Next cycle: ex_valid_o=1 and all fields loaded. Latency is 1 cycle.
- Drain: ex_valid_o & ex_ready_i with no accept. Next cycle: ex_valid_o=0; data fields may keep their last value.
- Flush has the highest priority. Next cycle ex_valid_o=0, and any same-cycle input is dropped. stall_cnt_o is unaffected.
- reg_write_o = stored reg_write & ex_valid_o.
- Forwarding function fwd(addr, rf):
  - exm_we_i & exm_addr_i==addr & addr!=0 → exm_data_i;
  - else wb_we_i & wb_addr_i==addr & addr!=0 → wb_data_i;
  - else rf.
  - EX/MEM has priority over MEM/WB. Address 0 is never forwarded.
- Capture values:
  - src1 = id_shift_src_i ? {27'b0, id_shamt_i} : fwd(rs, id_rs_data_i).
  - src2 = id_alu_src_i ? id_imm_i : fwd(rt, id_rt_data_i).
- Hold refresh: while ex_valid_o & !ex_ready_i & !flush_i, each register-sourced operand re-evaluates fwd(stored addr, current output value) every cycle. This replaces the value only on a match. Immediate- and shamt-sourced operands never change while held.
- When an accept and a refresh coincide, the accept wins.
- Stall counter: increments each cycle ex_valid_o & !ex_ready_i, and saturates at 2^CW-1. It is cleared only by reset.
- No arithmetic is performed in this block. Widths pass through unchanged; shamt is zero-extended.

Test Plan:
- Reset mid-hold: load ADD, hold with ex_ready_i=0, assert rst_i between clock edges → ex_valid_o, src1_o, src2_o and stall_cnt_o read 0 immediately, without waiting for a clock edge.
- Basic pass: ADD, rs=3 (0x5), rt=4 (0x7), no forward, ex_ready_i=1 → next cycle src1_o=5, src2_o=7, alu_ctrl_o=0010, ex_valid_o=1; next cycle with id_valid_i=0 → ex_valid_o=0.
- Forward priority: rs=8, exm (we=1, addr 8, 0xAAAA), wb (we=1, addr 8, 0xBBBB), rf=0x1 → src1_o=0xAAAA. Repeat with exm_we_i=0 → 0xBBBB. Repeat with rs=0 and both matching addr 0 → rf value.
- Hold refresh: SUB rt=9, ex_ready_i=0 for 3 cycles; cycle 2 wb writes r9=0x1234 → src2_o=0x1234 from cycle 3 on, stall_cnt_o=3, id_ready_o=0 throughout.
- SRA/LUI operand select: SRA shamt=4, rt=0xF0000000 → src1_o=4, src2_o=0xF0000000, alu_ctrl_o=1000. LUI imm=0x00001234, alu_src=1 → src2_o=0x1234, alu_ctrl_o=0101. Held SRA with wb r0/r4 writes → src1_o stays 4.
- Flush vs accept: held instruction with ex_ready_i=0 and new id_valid_i=1; assert flush_i → id_ready_o=1, next cycle ex_valid_o=0, reg_write_o=0, new instruction dropped.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register that feeds the EX-stage ALU.
// It selects operands, forwards results from EX/MEM and MEM/WB (both when an
// instruction is captured and while it is held), uses a valid/ready handshake
// with flush, and keeps a saturating stall counter.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          id_valid_i,
  output logic          id_ready_o,
  input  logic [DW-1:0] id_rs_data_i,
  input  logic [DW-1:0] id_rt_data_i,
  input  logic [AW-1:0] id_rs_addr_i,
  input  logic [AW-1:0] id_rt_addr_i,
  input  logic [AW-1:0] id_rd_addr_i,
  input  logic [DW-1:0] id_imm_i,
  input  logic [4:0]    id_shamt_i,
  input  logic [3:0]    id_alu_ctrl_i,
  input  logic          id_alu_src_i,
  input  logic          id_shift_src_i,
  input  logic          id_reg_write_i,
  input  logic          exm_we_i,
  input  logic [AW-1:0] exm_addr_i,
  input  logic [DW-1:0] exm_data_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic          flush_i,
  input  logic          ex_ready_i,
  output logic          ex_valid_o,
  output logic [DW-1:0] src1_o,
  output logic [DW-1:0] src2_o,
  output logic [3:0]    alu_ctrl_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          reg_write_o,
  output logic [CW-1:0] stall_cnt_o
);

  logic          ex_valid;
  logic          reg_write;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic          shift_src;
  logic          alu_src;
  logic          accept;
  logic          hold;
  logic [DW-1:0] cap_src1;
  logic [DW-1:0] cap_src2;
  logic [DW-1:0] hold_src1;
  logic [DW-1:0] hold_src2;

  // EX/MEM wins over MEM/WB; r0 is hardwired, so it is never forwarded.
  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] addr,
                                        input logic [DW-1:0] rf);
    if (exm_we_i && exm_addr_i == addr && addr != '0)
      return exm_data_i;
    else if (wb_we_i && wb_addr_i == addr && addr != '0)
      return wb_data_i;
    else
      return rf;
  endfunction

  assign id_ready_o  = !ex_valid || ex_ready_i || flush_i;
  assign accept      = id_valid_i && id_ready_o && !flush_i;
  assign hold        = ex_valid && !ex_ready_i && !flush_i;
  assign ex_valid_o  = ex_valid;
  assign reg_write_o = reg_write && ex_valid;

  // Operand values for a new capture and for refreshing a held instruction.
  always_comb begin
    cap_src1  = id_shift_src_i ? {{(DW-5){1'b0}}, id_shamt_i}
                               : fwd(id_rs_addr_i, id_rs_data_i);
    cap_src2  = id_alu_src_i ? id_imm_i : fwd(id_rt_addr_i, id_rt_data_i);
    hold_src1 = shift_src ? src1_o : fwd(rs_addr, src1_o);
    hold_src2 = alu_src   ? src2_o : fwd(rt_addr, src2_o);
  end

  // Pipeline register: flush kills, accept loads, hold refreshes forwarded operands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid   <= 1'b0;
      src1_o     <= '0;
      src2_o     <= '0;
      alu_ctrl_o <= '0;
      rd_addr_o  <= '0;
      reg_write  <= 1'b0;
      rs_addr    <= '0;
      rt_addr    <= '0;
      shift_src  <= 1'b0;
      alu_src    <= 1'b0;
    end else if (flush_i) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      src1_o     <= cap_src1;
      src2_o     <= cap_src2;
      alu_ctrl_o <= id_alu_ctrl_i;
      rd_addr_o  <= id_rd_addr_i;
      reg_write  <= id_reg_write_i;
      rs_addr    <= id_rs_addr_i;
      rt_addr    <= id_rt_addr_i;
      shift_src  <= id_shift_src_i;
      alu_src    <= id_alu_src_i;
    end else if (hold) begin
      src1_o <= hold_src1;
      src2_o <= hold_src2;
    end else if (ex_valid && ex_ready_i) begin
      ex_valid <= 1'b0;
    end
  end

  // Count cycles where a valid instruction is stuck waiting on EX; saturate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_o <= '0;
    else if (ex_valid && !ex_ready_i && stall_cnt_o != '1)
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: handshake, forwarding, hold refresh,
// operand select, flush, async reset and stall counter saturation.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_ready;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [AW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
  logic [4:0]    id_shamt;
  logic [3:0]    id_alu_ctrl;
  logic          id_alu_src, id_shift_src, id_reg_write;
  logic          exm_we, wb_we;
  logic [AW-1:0] exm_addr, wb_addr;
  logic [DW-1:0] exm_data, wb_data;
  logic          flush, ex_ready, ex_valid;
  logic [DW-1:0] src1, src2;
  logic [3:0]    alu_ctrl;
  logic [AW-1:0] rd_addr;
  logic          reg_write;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data),
    .id_rs_addr_i(id_rs_addr), .id_rt_addr_i(id_rt_addr), .id_rd_addr_i(id_rd_addr),
    .id_imm_i(id_imm), .id_shamt_i(id_shamt), .id_alu_ctrl_i(id_alu_ctrl),
    .id_alu_src_i(id_alu_src), .id_shift_src_i(id_shift_src), .id_reg_write_i(id_reg_write),
    .exm_we_i(exm_we), .exm_addr_i(exm_addr), .exm_data_i(exm_data),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .flush_i(flush), .ex_ready_i(ex_ready), .ex_valid_o(ex_valid),
    .src1_o(src1), .src2_o(src2), .alu_ctrl_o(alu_ctrl), .rd_addr_o(rd_addr),
    .reg_write_o(reg_write), .stall_cnt_o(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] ctrl, input logic [AW-1:0] rs, input logic [DW-1:0] rsd,
                       input logic [AW-1:0] rt, input logic [DW-1:0] rtd,
                       input logic asrc, input logic ssrc, input logic [DW-1:0] imm,
                       input logic [4:0] sh);
    id_valid = 1'b1; id_alu_ctrl = ctrl;
    id_rs_addr = rs; id_rs_data = rsd; id_rt_addr = rt; id_rt_data = rtd;
    id_alu_src = asrc; id_shift_src = ssrc; id_imm = imm; id_shamt = sh;
    id_rd_addr = 5'd2; id_reg_write = 1'b1;
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_shamt = 0; id_alu_ctrl = 0;
    id_alu_src = 0; id_shift_src = 0; id_reg_write = 0;
    exm_we = 0; exm_addr = 0; exm_data = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    flush = 0; ex_ready = 1;
    #12;
    chk("rst_valid", ex_valid, 0);
    chk("rst_src1", src1, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_ready", id_ready, 1);
    @(negedge clk); rst = 1'b0;
    step();

    // Basic pass: ADD r3(5) + r4(7)
    instr(4'b0010, 5'd3, 32'h5, 5'd4, 32'h7, 0, 0, 0, 0);
    step();
    chk("add_valid", ex_valid, 1);
    chk("add_src1", src1, 32'h5);
    chk("add_src2", src2, 32'h7);
    chk("add_ctrl", alu_ctrl, 4'b0010);
    chk("add_rw", reg_write, 1);
    chk("add_rd", rd_addr, 5'd2);
    id_valid = 0;
    step();
    chk("drain_valid", ex_valid, 0);
    chk("drain_rw", reg_write, 0);

    // Forward priority
    instr(4'b0010, 5'd8, 32'h1, 5'd4, 32'h7, 0, 0, 0, 0);
    exm_we = 1; exm_addr = 5'd8; exm_data = 32'hAAAA;
    wb_we = 1; wb_addr = 5'd8; wb_data = 32'hBBBB;
    step();
    chk("fwd_exm", src1, 32'hAAAA);
    exm_we = 0;
    step();
    chk("fwd_wb", src1, 32'hBBBB);
    exm_we = 1; exm_addr = 0; wb_addr = 0; id_rs_addr = 0;
    step();
    chk("fwd_r0", src1, 32'h1);
    exm_we = 0; wb_we = 0; id_valid = 0;
    step();

    // Hold refresh: SUB r1(0x10) - r9(0x55), EX stalled
    ex_ready = 0;
    instr(4'b0110, 5'd1, 32'h10, 5'd9, 32'h55, 0, 0, 0, 0);
    step();
    chk("hold_cap_src2", src2, 32'h55);
    chk("hold_stall0", stall_cnt, 0);
    id_alu_ctrl = 4'b0000; id_rt_data = 32'h99;   // new instruction waits
    chk("hold_ready1", id_ready, 0);
    step();
    wb_we = 1; wb_addr = 5'd9; wb_data = 32'h1234;
    chk("hold_ready2", id_ready, 0);
    step();
    wb_we = 0;
    chk("hold_src2_fwd", src2, 32'h1234);
    chk("hold_ready3", id_ready, 0);
    step();
    chk("hold_src2_keep", src2, 32'h1234);
    chk("hold_src1", src1, 32'h10);
    chk("hold_ctrl", alu_ctrl, 4'b0110);
    chk("hold_stall3", stall_cnt, 3);

    // Flush vs accept
    flush = 1;
    #1;
    chk("flush_ready", id_ready, 1);
    step();
    flush = 0; id_valid = 0;
    chk("flush_valid", ex_valid, 0);
    chk("flush_rw", reg_write, 0);
    chk("flush_stall", stall_cnt, 4);
    step();
    chk("flush_dropped", ex_valid, 0);

    // SRA: src1 = shamt 4, src2 = r5
    instr(4'b1000, 5'd4, 32'h99, 5'd5, 32'hF000_0000, 0, 1, 0, 5'd4);
    step();
    id_valid = 0;
    chk("sra_src1", src1, 32'h4);
    chk("sra_src2", src2, 32'hF000_0000);
    chk("sra_ctrl", alu_ctrl, 4'b1000);
    wb_we = 1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    step();
    wb_addr = 5'd4; wb_data = 32'hBEEF;
    step();
    wb_we = 0;
    chk("sra_held_src1", src1, 32'h4);
    chk("sra_held_src2", src2, 32'hF000_0000);
    chk("sra_stall", stall_cnt, 6);

    // LUI: src2 = immediate; immediate is not refreshed while held
    ex_ready = 1;
    instr(4'b0101, 5'd0, 32'h0, 5'd7, 32'h3, 1, 0, 32'h0000_1234, 0);
    step();
    chk("lui_src2", src2, 32'h1234);
    chk("lui_ctrl", alu_ctrl, 4'b0101);
    ex_ready = 0; id_valid = 0;
    wb_we = 1; wb_addr = 5'd7; wb_data = 32'h7777;
    step();
    wb_we = 0;
    chk("lui_held_src2", src2, 32'h1234);
    chk("lui_stall", stall_cnt, 7);

    // Async reset mid-hold, checked before the next edge
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_src1", src1, 0);
    chk("arst_src2", src2, 0);
    chk("arst_stall", stall_cnt, 0);
    @(negedge clk); rst = 1'b0;

    // Saturation: hold for 20 cycles with a 4-bit counter
    instr(4'b0010, 5'd3, 32'h5, 5'd4, 32'h7, 0, 0, 0, 0);
    step();
    id_valid = 0;
    for (int i = 0; i < 20; i++) step();
    chk("stall_sat", stall_cnt, 4'hF);
    chk("sat_valid", ex_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
